i2s_tx: RTL
===========

Name: i2s_tx

Overview:
I2S transmitter for the codec DAC path. It takes parallel left/right audio samples from the DSP datapath through a one-deep holding buffer. It generates SCLK and LRCLK from the system clock and serializes each sample MSB-first on SDout in standard I2S format, with a one-SCLK data delay after each LRCLK edge. Its control is a 4-bit one-hot state register.

Parameters:
DATA_W, 24, sample width per channel.
SCLK_DIV, 32, clk cycles per SCLK period; even, >=4.
BITS_PER_CH, 32, SCLK periods per channel half-frame; must be >= DATA_W+1.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
en  in  1  transmit enable.
ld  in  1  one-clk strobe; captures lft_in/rght_in into the holding buffer.
lft_in  in  DATA_W  left sample, two's complement.
rght_in  in  DATA_W  right sample.
SCLK  out  1  serial bit clock to codec.
LRCLK  out  1  word select; 0 = left, 1 = right.
SDout  out  1  serial data; changes only at SCLK falling edges.
frm_start  out  1  one-clk pulse when the holding buffer is transferred to the active registers.
underrun  out  1  one-clk pulse when a frame starts with no new sample loaded.
state  out  4  one-hot state, for debug.

Behaviour:
- Reset and clocking
  - Reset is synchronous active-high; clk and rst are the only clock/reset.
  - Reset values: state=IDLE (4'b0001), SCLK=0, LRCLK=1, SDout=0, frm_start=0, underrun=0.
  - Reset also clears hold_vld, sclk_cnt, bit_cnt and the shift register.
  - rst asserted mid-frame: next edge returns to reset values; no partial frame completes.
- States: IDLE=0001, WAIT=0010, LEFT=0100, RIGHT=1000.
  - Any non-one-hot value goes to IDLE on the next clk.
- Counters
  - sclk_cnt counts 0..SCLK_DIV-1 only in LEFT/RIGHT; held at 0 in IDLE/WAIT.
  - SCLK = (sclk_cnt >= SCLK_DIV/2).
  - An SCLK fall event is sclk_cnt wrapping from SCLK_DIV-1 to 0.
  - bit_cnt 0..BITS_PER_CH-1 increments on each fall event.
- Holding buffer
  - ld captures both channels and sets hold_vld.
  - ld while hold_vld=1 overwrites (latest wins).
  - ld in the same cycle as a transfer: the new data is kept and hold_vld stays 1.
- Transitions
  - IDLE -> WAIT when en=1.
  - WAIT -> IDLE if en=0.
  - WAIT -> LEFT when hold_vld=1. On that edge: active<=hold, hold_vld<=0, LRCLK<=0, frm_start pulses, counters = 0.
  - LEFT -> RIGHT on the fall event where bit_cnt wraps: LRCLK<=1.
  - RIGHT -> LEFT on bit_cnt wrap when en=1: LRCLK<=0, transfer as above.
    - If hold_vld=0 at this point: active is unchanged (previous sample repeated) and underrun pulses; frm_start does not pulse.
  - RIGHT -> IDLE on bit_cnt wrap when en=0: SCLK=0, LRCLK=1, SDout=0.
  - en deasserted in LEFT or mid-RIGHT has no effect until the end of the right half-frame.
- Data
  - At the fall event where the new bit_cnt = k: SDout = chan[DATA_W-k] for 1<=k<=DATA_W, else 0.
  - Result: the MSB is driven one SCLK after the LRCLK edge; bits are zero-padded to BITS_PER_CH.
- Frame length is 2*BITS_PER_CH*SCLK_DIV clks (2048 at defaults).
- Latency from the WAIT->LEFT edge to MSB valid on SDout is SCLK_DIV clks.

Decomposition:
- Package i2s_tx_pkg: one-hot state typedef with IDLE/WAIT/LEFT/RIGHT localparams, and defaults for the three parameters.
- One natural sub-module, i2s_sclk_gen: owns sclk_cnt and bit_cnt, and outputs SCLK, fall_evt and ch_wrap.
- The FSM, holding buffer and shift register stay in i2s_tx.

Test Plan:
1. Reset
   - Stimulus: rst=1 for 2 clks with en=1 and ld=1.
   - Required: state=0001, SCLK=0, LRCLK=1, SDout=0, frm_start=0.
2. Single frame
   - Stimulus: ld with lft_in=24'hA5C3F0, rght_in=24'h000001, then en=1.
   - Required: frm_start pulses at entry to LEFT. SDout sampled on SCLK rise shows left bits 1,0,1,0,0,1,0,1,... then 8 zeros.
   - Required: LRCLK rises 1024 clks later; right half reads 23 zeros, a 1, then 8 zeros.
3. Underrun
   - Stimulus: no ld during the first frame.
   - Required: at clk 2048, underrun pulses, frm_start=0, and left repeats A5C3F0.
4. Overwrite and simultaneous load
   - Stimulus: ld 24'h111111 then ld 24'h222222 before the frame boundary. Next frame, ld in the exact transfer cycle.
   - Required: 222222 is transmitted, and hold_vld remains 1 afterwards.
5. Graceful stop
   - Stimulus: en=0 at the midpoint of LEFT.
   - Required: the frame completes; IDLE reached at clk 2048 with SCLK=0, LRCLK=1.
6. Reset mid-RIGHT
   - Stimulus: rst=1 for 1 clk during RIGHT.
   - Required: next edge gives reset values, then with en=1 and no ld the block stays in WAIT (0010).

Source files
------------

// File: rtl/i2s_tx_pkg.sv
// Shared definitions for the I2S transmitter: one-hot control states and
// default geometry (sample width, SCLK divider, bits per channel).
package i2s_tx_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        WAIT  = 4'b0010,
        LEFT  = 4'b0100,
        RIGHT = 4'b1000
    } state_e;

    localparam int DATA_W_DEF      = 24;
    localparam int SCLK_DIV_DEF    = 32;
    localparam int BITS_PER_CH_DEF = 32;

endpackage

// File: rtl/i2s_sclk_gen.sv
// Bit-clock generator: divides clk into SCLK while running and tracks the
// bit position inside the current channel half-frame.
module i2s_sclk_gen
    import i2s_tx_pkg::*;
#(
    parameter int SCLK_DIV    = SCLK_DIV_DEF,
    parameter int BITS_PER_CH = BITS_PER_CH_DEF,
    localparam int SC_W       = $clog2(SCLK_DIV),
    localparam int BC_W       = $clog2(BITS_PER_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run_i,
    output logic            sclk_o,
    output logic            fall_evt_o,
    output logic            ch_wrap_o,
    output logic [BC_W-1:0] bit_cnt_o
);

    logic [SC_W-1:0] sclk_cnt_q;
    logic [SC_W-1:0] sclk_cnt_d;
    logic [BC_W-1:0] bit_cnt_q;
    logic [BC_W-1:0] bit_cnt_d;
    logic            sclk_q;

    // Next-count logic; counters sit at zero whenever the transmitter is not shifting
    always_comb begin
        fall_evt_o = run_i && (sclk_cnt_q == SC_W'(SCLK_DIV - 1));
        ch_wrap_o  = fall_evt_o && (bit_cnt_q == BC_W'(BITS_PER_CH - 1));
        sclk_cnt_d = sclk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (!run_i) begin
            sclk_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (fall_evt_o) begin
            sclk_cnt_d = '0;
            bit_cnt_d  = ch_wrap_o ? '0 : bit_cnt_q + BC_W'(1);
        end else begin
            sclk_cnt_d = sclk_cnt_q + SC_W'(1);
        end
    end

    // Counter and SCLK registers; SCLK is decoded from the next count so it is glitch-free
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b0;
        end else begin
            sclk_cnt_q <= sclk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= (sclk_cnt_d >= SC_W'(SCLK_DIV / 2));
        end
    end

    assign sclk_o    = sclk_q;
    assign bit_cnt_o = bit_cnt_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep sample holding buffer, one-hot control FSM and
// MSB-first serializer with the standard one-SCLK delay after each LRCLK edge.
module i2s_tx
    import i2s_tx_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SCLK_DIV    = SCLK_DIV_DEF,
    parameter int BITS_PER_CH = BITS_PER_CH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              ld,
    input  logic [DATA_W-1:0] lft_in,
    input  logic [DATA_W-1:0] rght_in,
    output logic              SCLK,
    output logic              LRCLK,
    output logic              SDout,
    output logic              frm_start,
    output logic              underrun,
    output logic [3:0]        state
);

    localparam int BC_W = $clog2(BITS_PER_CH);

    state_e            state_q;
    logic              lrclk_q;
    logic              sdout_q;
    logic              frm_q;
    logic              und_q;
    logic [DATA_W-1:0] hold_l_q;
    logic [DATA_W-1:0] hold_r_q;
    logic              hold_vld_q;
    logic [DATA_W-1:0] act_l_q;
    logic [DATA_W-1:0] act_r_q;
    logic [DATA_W-1:0] sh_q;

    logic              run_s;
    logic              fall_s;
    logic              wrap_s;
    logic [BC_W-1:0]   bit_cnt_s;
    logic              next_frame_s;
    logic              xfer_s;
    logic              data_bit_s;

    i2s_sclk_gen #(
        .SCLK_DIV    (SCLK_DIV),
        .BITS_PER_CH (BITS_PER_CH)
    ) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .run_i      (run_s),
        .sclk_o     (SCLK),
        .fall_evt_o (fall_s),
        .ch_wrap_o  (wrap_s),
        .bit_cnt_o  (bit_cnt_s)
    );

    // Frame-start decode; the new bit position k = bit_cnt+1 carries data while k <= DATA_W
    always_comb begin
        run_s        = (state_q == LEFT) || (state_q == RIGHT);
        next_frame_s = ((state_q == WAIT) && en && hold_vld_q) ||
                       ((state_q == RIGHT) && wrap_s && en);
        xfer_s       = next_frame_s && hold_vld_q;
        data_bit_s   = (bit_cnt_s < BC_W'(DATA_W));
    end

    // Holding buffer: a load always wins, even in the cycle the old contents are transferred
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            hold_vld_q <= 1'b0;
        end else if (ld) begin
            hold_l_q   <= lft_in;
            hold_r_q   <= rght_in;
            hold_vld_q <= 1'b1;
        end else if (xfer_s) begin
            hold_vld_q <= 1'b0;
        end
    end

    // Control FSM with registered LRCLK/SDout/pulses and the serializer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lrclk_q <= 1'b1;
            sdout_q <= 1'b0;
            frm_q   <= 1'b0;
            und_q   <= 1'b0;
            act_l_q <= '0;
            act_r_q <= '0;
            sh_q    <= '0;
        end else begin
            frm_q <= 1'b0;
            und_q <= 1'b0;
            if (next_frame_s) begin
                state_q <= LEFT;
                lrclk_q <= 1'b0;
                sdout_q <= 1'b0;
                if (hold_vld_q) begin
                    act_l_q <= hold_l_q;
                    act_r_q <= hold_r_q;
                    sh_q    <= hold_l_q;
                    frm_q   <= 1'b1;
                end else begin
                    // no fresh sample: replay the previous one
                    sh_q    <= act_l_q;
                    und_q   <= 1'b1;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        lrclk_q <= 1'b1;
                        sdout_q <= 1'b0;
                        if (en) begin
                            state_q <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (!en) begin
                            state_q <= IDLE;
                        end
                    end
                    LEFT, RIGHT: begin
                        if (fall_s) begin
                            if (wrap_s) begin
                                sdout_q <= 1'b0;
                                lrclk_q <= 1'b1;
                                if (state_q == LEFT) begin
                                    state_q <= RIGHT;
                                    sh_q    <= act_r_q;
                                end else begin
                                    state_q <= IDLE;
                                end
                            end else if (data_bit_s) begin
                                sdout_q <= sh_q[DATA_W-1];
                                sh_q    <= {sh_q[DATA_W-2:0], 1'b0};
                            end else begin
                                sdout_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        lrclk_q <= 1'b1;
                        sdout_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign LRCLK     = lrclk_q;
    assign SDout     = sdout_q;
    assign frm_start = frm_q;
    assign underrun  = und_q;
    assign state     = state_q;

endmodule
